// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
// Module : dmem_port_arbiter_if
// Brief  : Requester-side access bundle for dmem_port_arbiter (one per port).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic                req;
    logic                we;
    logic [ADDR_LEN-1:0] addr;
    logic [DATA_LEN-1:0] wdata;
    logic [1:0]          size;
    logic                gnt;
    logic                rvalid;
    logic [DATA_LEN-1:0] rdata;

    modport master (output req, we, addr, wdata, size, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, size, output gnt, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module : dmem_port_arbiter
// Brief  : Two-requester arbiter sharing one single-port data memory.
//          Optional macro DMEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  port0,
    dmem_port_arbiter_if.slave  port1,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [1:0]          mem_size,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_LEN-1:0] r_addr;
    logic [DATA_LEN-1:0] r_wdata;
    logic [1:0]          r_size;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic                r_mem_we;
    logic                r_mem_re;

    logic                w_win0;
    logic                w_win1;
    logic                w_sel_we;
    logic [ADDR_LEN-1:0] w_sel_addr;
    logic [DATA_LEN-1:0] w_sel_wdata;
    logic [1:0]          w_sel_size;

    always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        w_win0 = port0.req;
`else
        // On a tie the port that did not win last time goes first
        w_win0 = port0.req && (!port1.req || r_last);
`endif
        w_win1      = port1.req && !w_win0;
        w_sel_we    = w_win1 ? port1.we    : port0.we;
        w_sel_addr  = w_win1 ? port1.addr  : port0.addr;
        w_sel_wdata = w_win1 ? port1.wdata : port0.wdata;
        w_sel_size  = w_win1 ? port1.size  : port0.size;
        // Size 3 is not a legal encoding; treat it as a word access
        if (w_sel_size == 2'd3) begin
            w_sel_size = 2'd2;
        end
    end

    // The command register doubles as the held mem_* bus value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= 2'd0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_re  <= 1'b0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_re  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_win0 || w_win1) begin
                        r_owner  <= w_win1;
                        r_last   <= w_win1;
                        r_we     <= w_sel_we;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_size   <= w_sel_size;
                        r_gnt0   <= w_win0;
                        r_gnt1   <= w_win1;
                        r_mem_we <= w_sel_we;
                        r_mem_re <= !w_sel_we;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rvalid0 <= !r_owner;
                        r_rvalid1 <= r_owner;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_size     = r_size;
    assign mem_we       = r_mem_we;
    assign mem_re       = r_mem_re;

    assign port0.gnt    = r_gnt0;
    assign port1.gnt    = r_gnt1;
    assign port0.rvalid = r_rvalid0;
    assign port1.rvalid = r_rvalid1;
    assign port0.rdata  = r_rvalid0 ? mem_rdata : '0;
    assign port1.rdata  = r_rvalid1 ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module : tb_dmem_port_arbiter
// Brief  : Randomized self-checking bench with a cycle-timeline reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int NSLOT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_LEN(AW), .DATA_LEN(DW)) p0_if ();
    dmem_port_arbiter_if #(.ADDR_LEN(AW), .DATA_LEN(DW)) p1_if ();

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_size;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    dmem_port_arbiter #(.ADDR_LEN(AW), .DATA_LEN(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .port0     (p0_if),
        .port1     (p1_if),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    // Requester drive state
    logic        a_req   [2];
    logic        a_we    [2];
    logic [31:0] a_addr  [2];
    logic [31:0] a_wdata [2];
    logic [1:0]  a_size  [2];
    int          left    [2];
    int          we_mode [2];
    bit          auto_mode;

    assign p0_if.req   = a_req[0];
    assign p0_if.we    = a_we[0];
    assign p0_if.addr  = a_addr[0];
    assign p0_if.wdata = a_wdata[0];
    assign p0_if.size  = a_size[0];
    assign p1_if.req   = a_req[1];
    assign p1_if.we    = a_we[1];
    assign p1_if.addr  = a_addr[1];
    assign p1_if.wdata = a_wdata[1];
    assign p1_if.size  = a_size[1];

    function automatic logic [31:0] pat(input logic [7:0] i);
        return {i, ~i, i ^ 8'h5A, 8'hC3};
    endfunction

    // Memory environment: unwritten words return a fixed pattern
    logic [31:0] tb_mem [256];
    bit          tb_wr  [256];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= tb_wr[mem_addr[9:2]] ? tb_mem[mem_addr[9:2]] : pat(mem_addr[9:2]);
        if (mem_we) begin
            tb_mem[mem_addr[9:2]] <= mem_wdata;
            tb_wr[mem_addr[9:2]]  <= 1'b1;
        end
    end

    // Reference model: expected outputs per future cycle
    typedef struct packed {
        logic        g0, g1, we, re, rv0, rv1;
        logic [31:0] addr, wdata, rdata;
        logic [1:0]  size;
    } slot_t;

    slot_t       sl [NSLOT];
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];
    logic [31:0] h_addr, h_wdata;
    logic [1:0]  h_size;
    int          cyc, idle_at, m_last;
    int          gq[$];
    int          we_cyc[$];
    logic [31:0] last_rd0;
    logic [1:0]  last_re_size, last_we_size;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic new_fields(input int p);
        int unsigned idx;
        idx        = $urandom_range(0, 255);
        a_addr[p]  = ($urandom() & 32'hFFFF_FC00) | (idx << 2);
        a_wdata[p] = $urandom();
        a_size[p]  = 2'($urandom_range(0, 3));
        a_we[p]    = (we_mode[p] == 2) ? 1'($urandom_range(0, 1)) : (we_mode[p] == 1);
    endtask

    task automatic start(input int p, input int wm, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [1:0] sz, input int n);
        we_mode[p] = wm;
        a_we[p]    = (wm == 1);
        a_addr[p]  = ad;
        a_wdata[p] = wd;
        a_size[p]  = sz;
        left[p]    = n;
        a_req[p]   = 1'b1;
    endtask

    task automatic drive_port(input int p, input logic g);
        if (a_req[p] && g) begin
            left[p]--;
            if (left[p] <= 0) a_req[p] = 1'b0;
            else new_fields(p);
        end else if (!a_req[p] && auto_mode && $urandom_range(0, 3) == 0) begin
            left[p]  = $urandom_range(1, 3);
            a_req[p] = 1'b1;
            new_fields(p);
        end
    endtask

    task automatic predict();
        int    w;
        int    k1, k2;
        logic [7:0] idx;
        if (cyc < idle_at || !(a_req[0] || a_req[1])) return;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        w = a_req[0] ? 0 : 1;
`else
        if (a_req[0] && a_req[1]) w = 1 - m_last;
        else                      w = a_req[0] ? 0 : 1;
`endif
        m_last = w;
        idx = a_addr[w][9:2];
        k1  = (cyc + 1) % NSLOT;
        k2  = (cyc + 2) % NSLOT;
        sl[k1].g0    = (w == 0);
        sl[k1].g1    = (w == 1);
        sl[k1].we    = a_we[w];
        sl[k1].re    = !a_we[w];
        sl[k1].addr  = a_addr[w];
        sl[k1].wdata = a_wdata[w];
        sl[k1].size  = (a_size[w] == 2'd3) ? 2'd2 : a_size[w];
        if (a_we[w]) begin
            ref_mem[idx] = a_wdata[w];
            ref_wr[idx]  = 1'b1;
            idle_at      = cyc + 2;
        end else begin
            sl[k2].rv0   = (w == 0);
            sl[k2].rv1   = (w == 1);
            sl[k2].rdata = ref_wr[idx] ? ref_mem[idx] : pat(idx);
            idle_at      = cyc + 3;
        end
    endtask

    // Called at the falling edge of cycle cyc; returns at the next falling edge
    task automatic step();
        slot_t s;
        int    k;
        k     = cyc % NSLOT;
        s     = sl[k];
        sl[k] = '0;
        if (s.we || s.re) begin
            h_addr  = s.addr;
            h_wdata = s.wdata;
            h_size  = s.size;
        end
        chk("gnt0",      p0_if.gnt,    s.g0);
        chk("gnt1",      p1_if.gnt,    s.g1);
        chk("mem_we",    mem_we,       s.we);
        chk("mem_re",    mem_re,       s.re);
        chk("mem_addr",  mem_addr,     h_addr);
        chk("mem_wdata", mem_wdata,    h_wdata);
        chk("mem_size",  mem_size,     h_size);
        chk("rvalid0",   p0_if.rvalid, s.rv0);
        chk("rvalid1",   p1_if.rvalid, s.rv1);
        chk("rdata0",    p0_if.rdata,  s.rv0 ? s.rdata : 32'h0);
        chk("rdata1",    p1_if.rdata,  s.rv1 ? s.rdata : 32'h0);
        if (p0_if.gnt)    gq.push_back(0);
        if (p1_if.gnt)    gq.push_back(1);
        if (p0_if.rvalid) last_rd0 = p0_if.rdata;
        if (mem_re)       last_re_size = mem_size;
        if (mem_we) begin
            we_cyc.push_back(cyc);
            last_we_size = mem_size;
        end
        drive_port(0, p0_if.gnt);
        drive_port(1, p1_if.gnt);
        predict();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((a_req[0] || a_req[1] || cyc <= idle_at) && n < budget) begin
            step();
            n++;
        end
        if (a_req[0] || a_req[1] || cyc <= idle_at) chk("timeout", 1, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSLOT; i++) sl[i] = '0;
        h_addr  = '0;
        h_wdata = '0;
        h_size  = '0;
        m_last  = 1;
        for (int p = 0; p < 2; p++) begin
            a_req[p] = 1'b0;
            left[p]  = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        auto_mode = 1'b0;
        cyc       = 0;
        idle_at   = 0;
        for (int p = 0; p < 2; p++) begin
            we_mode[p] = 2;
            a_we[p]    = 1'b0;
            a_addr[p]  = '0;
            a_wdata[p] = '0;
            a_size[p]  = '0;
        end
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0",  p0_if.gnt,    0);
        chk("rst_gnt1",  p1_if.gnt,    0);
        chk("rst_rv0",   p0_if.rvalid, 0);
        chk("rst_rv1",   p1_if.rvalid, 0);
        chk("rst_we_re", {mem_we, mem_re}, 0);
        chk("rst_addr",  mem_addr,     0);
        chk("rst_size",  mem_size,     0);
        reset = 1'b0;

        // Both ports requesting continuously from reset
        gq.delete();
        start(0, 0, 32'h0000_0010, 32'h0, 2'd2, 4);
        start(1, 1, 32'h0000_0020, 32'h1, 2'd2, 4);
        repeat (12) step();
        chk("cont_cnt", gq.size() >= 4, 1);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        chk("cont_order", {gq[0][1:0], gq[1][1:0], gq[2][1:0], gq[3][1:0]}, 8'b00_00_00_00);
`else
        chk("cont_order", {gq[0][1:0], gq[1][1:0], gq[2][1:0], gq[3][1:0]}, 8'b00_01_00_01);
`endif
        drain(100);

        // Single write on port 1
        we_cyc.delete();
        gq.delete();
        start(1, 1, 32'h0000_0040, 32'h1234_5678, 2'd0, 1);
        drain(20);
        chk("wr1_pulses", we_cyc.size(), 1);
        chk("wr1_size",   last_we_size,  0);
        chk("wr1_gnt",    (gq.size() == 1) && (gq[0] == 1), 1);

        // Single read on port 0 of a known word
        start(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 2'd2, 1);
        drain(20);
        last_rd0 = '0;
        start(0, 0, 32'h0000_0100, 32'h0, 2'd2, 1);
        drain(20);
        chk("rd0_data", last_rd0, 32'hDEAD_BEEF);

        // Illegal size goes out as a word
        last_re_size = 2'd3;
        start(0, 0, 32'h0000_0200, 32'h0, 2'd3, 1);
        drain(20);
        chk("ill_size", last_re_size, 2);

        // Request held high across the grant
        we_cyc.delete();
        start(0, 1, 32'h0000_0080, 32'hA5A5_0001, 2'd2, 2);
        drain(20);
        chk("held_cnt", we_cyc.size(), 2);
        if (we_cyc.size() == 2) chk("held_gap", we_cyc[1] - we_cyc[0], 2);

        // Reset asserted during RESP of a port 0 read
        gq.delete();
        start(0, 0, 32'h0000_0300, 32'h0, 2'd2, 1);
        for (int i = 0; i < 20 && gq.size() == 0; i++) step();
        chk("rr_pre_rv0", p0_if.rvalid, 1);
        reset = 1'b1;
        #1;
        chk("rr_rv0",    p0_if.rvalid, 0);
        chk("rr_rdata0", p0_if.rdata,  0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset   = 1'b0;
        idle_at = cyc;
        gq.delete();
        start(0, 0, 32'h0000_0304, 32'h0, 2'd1, 1);
        start(1, 1, 32'h0000_0308, 32'h7, 2'd1, 1);
        drain(30);
        chk("rr_tie", (gq.size() == 2) && (gq[0] == 0), 1);

        // Randomized traffic
        we_mode[0] = 2;
        we_mode[1] = 2;
        auto_mode  = 1'b1;
        repeat (1500) step();
        auto_mode  = 1'b0;
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
